frame2axi_packer: RTL and testbench

Upstream producer for the two-channel FIFO-to-AXI write mux. It accepts a 32-bit sample stream from a DSP stage and packs samples into 128-bit write-data beats. It emits one 64-bit burst command per burst into a ring buffer in DDR. Its outputs drive one channel (cmd + wr) of the mux, and it reacts to that channel's full flags.

---
 rtl/frame2axi_packer.sv | 140 ++++++++++++++
 tb/tb_frame2axi_packer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/frame2axi_packer.sv
// Packs a 32-bit sample stream into 128-bit beats and emits one 64-bit burst command per burst into a DDR ring.
// All outputs are registered; s_ready follows fifo_full_wr one cycle late, relying on the FIFOs' prog-full margin.
module frame2axi_packer #(
  parameter int          BURST_BEATS = 16,
  parameter logic [31:0] RING_BYTES  = 32'h0010_0000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         frame_start,
  input  logic [31:0]  cfg_base_addr,
  input  logic         s_valid,
  input  logic [31:0]  s_data,
  input  logic         s_last,
  output logic         s_ready,
  output logic [63:0]  fifo_din_cmd,
  output logic         fifo_wr_en_cmd,
  input  logic         fifo_full_cmd,
  output logic [127:0] fifo_din_wr,
  output logic         fifo_wr_en_wr,
  input  logic         fifo_full_wr,
  output logic         busy,
  output logic         frame_done,
  output logic         start_err
);

  localparam logic [31:0] BURST_BYTES = 32'(BURST_BEATS) << 4;

  typedef enum logic [1:0] {IDLE, RUN, CMD, DONE} state_t;

  state_t            state;
  logic [31:0]       base_addr;
  logic [31:0]       offset;
  logic [1:0]        lane_cnt;
  logic [8:0]        beat_cnt;
  logic [3:0][31:0]  lanes;
  logic              frame_end;

  logic              handshake;
  logic              beat_done;
  logic              burst_done;
  logic [8:0]        beat_cnt_inc;
  logic [8:0]        beat_len;
  logic [31:0]       offset_inc;
  logic [31:0]       offset_nxt;
  logic [3:0][31:0]  beat_dat;

  assign handshake    = (state == RUN) && s_valid && s_ready;
  assign beat_done    = handshake && ((lane_cnt == 2'd3) || s_last);
  assign beat_cnt_inc = beat_cnt + 9'd1;
  assign burst_done   = beat_done && ((beat_cnt_inc == 9'(BURST_BEATS)) || s_last);
  assign beat_len     = beat_cnt - 9'd1;
  assign offset_inc   = offset + BURST_BYTES;
  assign offset_nxt   = (offset_inc == RING_BYTES) ? 32'd0 : offset_inc;

  // Lanes are cleared after every beat, so lanes above lane_cnt already read as zero padding.
  always_comb begin
    beat_dat           = lanes;
    beat_dat[lane_cnt] = s_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      base_addr      <= '0;
      offset         <= '0;
      lane_cnt       <= '0;
      beat_cnt       <= '0;
      lanes          <= '0;
      frame_end      <= 1'b0;
      s_ready        <= 1'b0;
      busy           <= 1'b0;
      frame_done     <= 1'b0;
      start_err      <= 1'b0;
      fifo_wr_en_cmd <= 1'b0;
      fifo_wr_en_wr  <= 1'b0;
      fifo_din_cmd   <= '0;
      fifo_din_wr    <= '0;
    end else begin
      fifo_wr_en_wr  <= 1'b0;
      fifo_wr_en_cmd <= 1'b0;
      frame_done     <= 1'b0;
      start_err      <= frame_start && (state != IDLE);
      case (state)
        IDLE: begin
          if (frame_start) begin
            base_addr <= cfg_base_addr;
            lane_cnt  <= '0;
            beat_cnt  <= '0;
            lanes     <= '0;
            frame_end <= 1'b0;
            s_ready   <= !fifo_full_wr;
            busy      <= 1'b1;
            state     <= RUN;
          end
        end
        RUN: begin
          s_ready <= !fifo_full_wr;
          if (handshake) begin
            if (beat_done) begin
              fifo_din_wr   <= beat_dat;
              fifo_wr_en_wr <= 1'b1;
              lanes         <= '0;
              lane_cnt      <= '0;
              beat_cnt      <= beat_cnt_inc;
              if (burst_done) begin
                frame_end <= s_last;
                s_ready   <= 1'b0;
                state     <= CMD;
              end
            end else begin
              lanes[lane_cnt] <= s_data;
              lane_cnt        <= lane_cnt + 2'd1;
            end
          end
        end
        CMD: begin
          if (!fifo_full_cmd) begin
            fifo_din_cmd   <= {24'd0, beat_len[7:0], base_addr + offset};
            fifo_wr_en_cmd <= 1'b1;
            offset         <= offset_nxt;
            beat_cnt       <= '0;
            if (frame_end) begin
              state <= DONE;
            end else begin
              s_ready <= !fifo_full_wr;
              state   <= RUN;
            end
          end
        end
        DONE: begin
          frame_done <= 1'b1;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame2axi_packer.sv
// Directed bench for frame2axi_packer: captures beat/command strobes into queues and compares against hand-built expectations.
module tb_frame2axi_packer;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         frame_start = 1'b0;
  logic [31:0]  cfg_base_addr = 32'h1000_0000;
  logic         s_valid = 1'b0;
  logic [31:0]  s_data = '0;
  logic         s_last = 1'b0;
  logic         s_ready;
  logic [63:0]  fifo_din_cmd;
  logic         fifo_wr_en_cmd;
  logic         fifo_full_cmd = 1'b0;
  logic [127:0] fifo_din_wr;
  logic         fifo_wr_en_wr;
  logic         fifo_full_wr = 1'b0;
  logic         busy;
  logic         frame_done;
  logic         start_err;

  frame2axi_packer #(.BURST_BEATS(16), .RING_BYTES(32'h0000_0400)) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .cfg_base_addr(cfg_base_addr),
    .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
    .fifo_din_cmd(fifo_din_cmd), .fifo_wr_en_cmd(fifo_wr_en_cmd), .fifo_full_cmd(fifo_full_cmd),
    .fifo_din_wr(fifo_din_wr), .fifo_wr_en_wr(fifo_wr_en_wr), .fifo_full_wr(fifo_full_wr),
    .busy(busy), .frame_done(frame_done), .start_err(start_err)
  );

  always #5 clk = ~clk;

  logic [127:0] beat_q[$];
  logic [63:0]  cmd_q[$];
  int           cmd_at_beats[$];
  int           checks = 0;
  int           errors = 0;
  int           acc_cnt = 0;
  logic [31:0]  exp_off = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (fifo_wr_en_wr) beat_q.push_back(fifo_din_wr);
      if (fifo_wr_en_cmd) begin
        cmd_q.push_back(fifo_din_cmd);
        cmd_at_beats.push_back(beat_q.size());
      end
    end
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic clear_q();
    beat_q.delete();
    cmd_q.delete();
    cmd_at_beats.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s_valid = 1'b0;
    s_last = 1'b0;
    frame_start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_off = 0;
    clear_q();
  endtask

  task automatic send_sample(input logic [31:0] d, input logic last);
    bit ok = 0;
    s_valid = 1'b1;
    s_data = d;
    s_last = last;
    for (int t = 0; t < 500; t++) begin
      if (s_ready) begin
        @(posedge clk);
        #1;
        ok = 1;
        acc_cnt++;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!ok) check("sample_timeout", 0, 1);
  endtask

  task automatic send_frame(input int n, input logic [31:0] v0, input int err_at, input bit has_last);
    frame_start = 1'b1;
    cfg_base_addr = 32'h1000_0000;
    @(posedge clk);
    #1;
    frame_start = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (i == err_at) begin
        frame_start = 1'b1;
        cfg_base_addr = 32'h2000_0000;
      end
      send_sample(v0 + 32'(i), has_last && (i == n - 1));
      if (i == err_at) begin
        frame_start = 1'b0;
        check("start_err_pulse", start_err, 1);
        check("busy_in_run", busy, 1);
      end
    end
    s_valid = 1'b0;
    s_last = 1'b0;
  endtask

  task automatic wait_done();
    bit seen = 0;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (frame_done) begin
        seen = 1;
        break;
      end
    end
    check("frame_done_seen", seen, 1);
    @(negedge clk);
    check("frame_done_pulse", frame_done, 0);
    check("busy_idle", busy, 0);
  endtask

  // Expected beats: sample idx 4j+k lands in lane k; lanes past the frame end are zero.
  task automatic check_frame(input int n, input logic [31:0] v0);
    int nb = (n + 3) / 4;
    int ncmd = (nb + 15) / 16;
    check("beat_count", beat_q.size(), nb);
    for (int j = 0; j < nb && j < beat_q.size(); j++) begin
      logic [127:0] e = '0;
      for (int k = 0; k < 4; k++)
        if (4 * j + k < n) e[32*k +: 32] = v0 + 32'(4 * j + k);
      check("beat_data", beat_q[j], e);
    end
    check("cmd_count", cmd_q.size(), ncmd);
    for (int c = 0; c < ncmd; c++) begin
      int bb = (nb - 16 * c > 16) ? 16 : nb - 16 * c;
      logic [63:0] e = {24'd0, 8'(bb - 1), 32'h1000_0000 + exp_off};
      if (c < cmd_q.size()) begin
        check("cmd_word", cmd_q[c], e);
        check("cmd_after_beats", cmd_at_beats[c], 16 * c + bb);
      end
      exp_off = (exp_off + 32'h100 == 32'h400) ? 32'h0 : exp_off + 32'h100;
    end
    clear_q();
  endtask

  initial begin
    do_reset();
    check("rst_s_ready", s_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_start_err", start_err, 0);
    check("rst_wr_en_cmd", fifo_wr_en_cmd, 0);
    check("rst_wr_en_wr", fifo_wr_en_wr, 0);
    check("rst_din_cmd", fifo_din_cmd, 0);
    check("rst_din_wr", fifo_din_wr, 0);

    // 64 samples: one full burst
    send_frame(64, 0, -1, 1);
    wait_done();
    if (beat_q.size() > 0) check("t1_beat0", beat_q[0], 128'h00000003_00000002_00000001_00000000);
    if (cmd_q.size() > 0) check("t1_cmd", cmd_q[0], 64'h0000_000F_1000_0000);
    check_frame(64, 0);

    // 70 samples: full burst plus a padded partial
    do_reset();
    send_frame(70, 0, -1, 1);
    wait_done();
    if (beat_q.size() > 17) check("t2_beat17", beat_q[17], 128'h0_00000045_00000044);
    if (cmd_q.size() > 1) check("t2_cmd2", cmd_q[1], 64'h0000_0001_1000_0100);
    check_frame(70, 0);

    // ring wrap over five frames
    do_reset();
    for (int f = 0; f < 5; f++) begin
      send_frame(64, 32'(f * 1000), -1, 1);
      wait_done();
      if (f == 4 && cmd_q.size() > 0) check("ring_wrap_addr", cmd_q[0][31:0], 32'h1000_0000);
      check_frame(64, 32'(f * 1000));
    end

    // backpressure on both FIFOs
    do_reset();
    acc_cnt = 0;
    fifo_full_cmd = 1'b1;
    fork
      send_frame(64, 32'h500, -1, 1);
      begin
        int hi = 0;
        for (int t = 0; t < 500 && acc_cnt < 6; t++) @(negedge clk);
        fifo_full_wr = 1'b1;
        for (int i = 0; i < 10; i++) begin
          @(negedge clk);
          if (s_ready) hi++;
        end
        fifo_full_wr = 1'b0;
        check("sready_low_while_full", hi, 0);
      end
      begin
        int early = 0;
        for (int t = 0; t < 500 && beat_q.size() < 16; t++) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          if (fifo_wr_en_cmd) early++;
        end
        check("cmd_held_while_full", early, 0);
        fifo_full_cmd = 1'b0;
        @(negedge clk);
        check("cmd_after_full_drop", fifo_wr_en_cmd, 1);
      end
    join
    wait_done();
    check_frame(64, 32'h500);

    // frame_start during RUN is flagged and ignored
    do_reset();
    send_frame(8, 32'h77, 3, 1);
    check("start_err_clears", start_err, 0);
    wait_done();
    check_frame(8, 32'h77);

    // reset mid-beat discards partial state and offset
    do_reset();
    send_frame(4, 32'h10, -1, 1);
    wait_done();
    check_frame(4, 32'h10);
    send_frame(3, 32'h20, -1, 0);
    do_reset();
    repeat (8) @(negedge clk);
    check("no_wr_after_rst", beat_q.size(), 0);
    check("no_cmd_after_rst", cmd_q.size(), 0);
    send_frame(4, 32'h100, -1, 1);
    wait_done();
    if (beat_q.size() > 0) check("rst_beat0", beat_q[0], 128'h00000103_00000102_00000101_00000100);
    if (cmd_q.size() > 0) check("rst_cmd_addr", cmd_q[0], 64'h0000_0000_1000_0000);
    check_frame(4, 32'h100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
